// File: rtl/inv_sb_engine.sv
// Iterative AES InvSubBytes + AddRoundKey engine: one byte per cycle through a
// single shared inverse S-box, MSB byte first, result published once complete.
module inv_sb_engine (
    input  logic         clk,
    input  logic         rst,
    input  logic         isb_start,
    input  logic [127:0] data,
    input  logic [127:0] key,
    output logic         isb_busy,
    output logic         isb_done,
    output logic [127:0] isb_out
);

    localparam int unsigned DATA_W = 128;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned POS_W  = 7;

    // FIPS-197 inverse S-box, entry 0x00 in the most significant byte
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   key_q;
    logic [DATA_W-1:0]   work_q;
    logic [DATA_W-1:0]   work_next;
    logic [POS_W-1:0]    pos;
    logic [BYTE_W-1:0]   cur_byte;
    logic [BYTE_W-1:0]   key_byte;
    logic [BYTE_W-1:0]   sub_byte;

    // Offset of entry b is (255-b)*8, i.e. the inverted index shifted by 3
    function automatic logic [BYTE_W-1:0] inv_sbox(input logic [BYTE_W-1:0] b);
        return INV_SBOX[{~b, 3'b000} +: BYTE_W];
    endfunction

    // Byte n lives at bit offset (15-n)*8, so the inverted counter gives the slot
    always_comb begin
        pos       = POS_W'({~cnt, 3'b000});
        cur_byte  = data_q[pos +: BYTE_W];
        key_byte  = key_q[pos +: BYTE_W];
        sub_byte  = inv_sbox(cur_byte) ^ key_byte;
        work_next = work_q;
        work_next[pos +: BYTE_W] = sub_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            data_q   <= '0;
            key_q    <= '0;
            work_q   <= '0;
            isb_busy <= 1'b0;
            isb_done <= 1'b0;
            isb_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    isb_done <= 1'b0;
                    if (isb_start) begin
                        data_q   <= data;
                        key_q    <= key;
                        cnt      <= '0;
                        isb_busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    work_q <= work_next;
                    cnt    <= cnt + CNT_W'(1);
                    // Last byte: publish the full word so no partial result leaks out
                    if (cnt == CNT_W'(15)) begin
                        isb_out  <= work_next;
                        isb_busy <= 1'b0;
                        isb_done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    isb_done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    isb_busy <= 1'b0;
                    isb_done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_sb_engine.sv
// Directed scoreboard bench for inv_sb_engine: expected words queued at start,
// popped and compared when isb_done fires.
module tb_inv_sb_engine;

    logic         clk;
    logic         rst;
    logic         isb_start;
    logic [127:0] data;
    logic [127:0] key;
    logic         isb_busy;
    logic         isb_done;
    logic [127:0] isb_out;

    int n_checks  = 0;
    int n_fail    = 0;
    int done_seen = 0;
    int excl_viol = 0;
    logic [127:0] exp_q[$];

    inv_sb_engine dut (
        .clk       (clk),
        .rst       (rst),
        .isb_start (isb_start),
        .data      (data),
        .key       (key),
        .isb_busy  (isb_busy),
        .isb_done  (isb_done),
        .isb_out   (isb_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Done pulse counter and busy/done exclusivity watch, sampled just after the edge
    always @(posedge clk) begin
        #1;
        if (isb_done) done_seen++;
        if (isb_busy && isb_done) excl_viol++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // mode 0: plain; 1: scramble data/key during RUN; 2: pulse start in RUN cycles 3 and 10
    task automatic run_op(input string tag, input logic [127:0] d, input logic [127:0] k,
                          input logic [127:0] exp, input int mode);
        logic [127:0] prev_out;
        logic [127:0] e;
        int lat;
        int busy_n;
        int d0;
        bit partial;
        bit got;
        lat = 0; busy_n = 0; partial = 0; got = 0;
        prev_out = isb_out;
        d0 = done_seen;
        data = d; key = k; isb_start = 1'b1;
        exp_q.push_back(exp);
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            isb_start = (mode == 2 && (i == 3 || i == 10));
            if (mode == 1) begin
                data = {$urandom(), $urandom(), $urandom(), $urandom()};
                key  = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            if (isb_done) begin
                got = 1;
                lat = i;
            end else begin
                if (isb_busy) busy_n++;
                if (isb_out !== prev_out) partial = 1;
            end
        end
        isb_start = 1'b0;
        e = exp_q.pop_front();
        chk({tag, "/out"}, isb_out, e);
        chk({tag, "/latency"}, 128'(lat), 128'd17);
        chk({tag, "/busy_cycles"}, 128'(busy_n), 128'd16);
        chk({tag, "/no_partial"}, 128'(partial), 128'd0);
        repeat ((mode == 2) ? 25 : 3) @(negedge clk);
        chk({tag, "/hold"}, isb_out, e);
        chk({tag, "/done_pulses"}, 128'(done_seen - d0), 128'd1);
    endtask

    initial begin
        logic [127:0] e;
        int last;
        int ndone;
        int d0;

        rst = 1'b1; isb_start = 1'b0; data = '0; key = '0;
        repeat (3) @(negedge clk);
        chk("reset/out", isb_out, 128'h0);
        chk("reset/busy", 128'(isb_busy), 128'd0);
        chk("reset/done", 128'(isb_done), 128'd0);
        rst = 1'b0;

        run_op("all16", {16{8'h16}}, 128'h0, {16{8'hFF}}, 0);
        run_op("all63_keyA5", {16{8'h63}}, {16{8'hA5}}, {16{8'hA5}}, 0);
        run_op("all00", 128'h0, 128'h0, {16{8'h52}}, 0);
        run_op("key_order", 128'h0, 128'h000102030405060708090A0B0C0D0E0F,
               128'h52535051565754555A5B58595E5F5C5D, 0);
        run_op("scramble", {8{16'h00FF}}, 128'h0, {8{16'h527D}}, 1);
        run_op("start_in_run", {4{32'h006316FF}}, 128'h0, {4{32'h5200FF7D}}, 2);

        // Start held high: back-to-back operations every 18 cycles
        data = {16{8'h16}}; key = 128'h0; isb_start = 1'b1;
        repeat (3) exp_q.push_back({16{8'hFF}});
        last = 0; ndone = 0;
        for (int i = 1; i <= 70 && ndone < 3; i++) begin
            @(negedge clk);
            if (isb_done) begin
                e = exp_q.pop_front();
                chk("b2b/out", isb_out, e);
                if (ndone == 0) chk("b2b/first_latency", 128'(i), 128'd17);
                else            chk("b2b/spacing", 128'(i - last), 128'd18);
                last = i;
                ndone++;
                if (ndone == 3) isb_start = 1'b0;
            end
        end
        isb_start = 1'b0;
        chk("b2b/count", 128'(ndone), 128'd3);
        exp_q.delete();
        repeat (3) @(negedge clk);

        // Reset in RUN cycle 8 abandons the operation
        d0 = done_seen;
        data = 128'h0; key = 128'h0; isb_start = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            isb_start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst/busy", 128'(isb_busy), 128'd0);
        chk("midrst/out", isb_out, 128'h0);
        repeat (20) @(negedge clk);
        chk("midrst/no_done", 128'(done_seen - d0), 128'd0);
        chk("midrst/out_later", isb_out, 128'h0);
        run_op("after_rst", {16{8'h63}}, {16{8'hA5}}, {16{8'hA5}}, 0);

        // Reset wins over start on the same edge
        rst = 1'b1; isb_start = 1'b1;
        @(negedge clk);
        rst = 1'b0; isb_start = 1'b0;
        chk("rst_start/busy", 128'(isb_busy), 128'd0);
        @(negedge clk);
        chk("rst_start/idle", 128'(isb_busy), 128'd0);

        // Start accepted in the first cycle after reset deasserts
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_op("first_after_rst", {8{16'h00FF}}, 128'h0, {8{16'h527D}}, 0);

        chk("busy_done_exclusive", 128'(excl_viol), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
